// File: rtl/req_if.sv
// req_if: valid/ready request handshake from one initiator to the register-file arbiter.
interface req_if;
   logic valid;
   logic ready;
   modport master (output valid, input ready);
   modport slave (input valid, output ready);
endinterface

// File: rtl/acc_sender.sv
// acc_sender: per-accumulator request FIFOs feeding one req_if each (optional ACC_SENDER_BYPASS_EN).
module acc_sender #(
   parameter int N_ACC    = 3,
   parameter int DEPTH    = 4,
   parameter int GC_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enq,
   input  logic [$clog2(N_ACC)-1:0]       enq_acc,
   input  logic [31:0]                    enq_data,
   input  logic [GC_WIDTH-1:0]            enq_stamp,
   output logic [N_ACC-1:0]               acc_full,
   req_if.master                          acc_req [N_ACC],
   output logic [N_ACC-1:0][31:0]         acc_data,
   output logic [N_ACC-1:0][GC_WIDTH-1:0] gc_stamp,
   output logic                           idle,
   output logic                           overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int AW = $clog2(N_ACC);
   logic [N_ACC-1:0] busy, drop;
   for (genvar i = 0; i < N_ACC; i++) begin : g_fifo
      logic [PW-1:0]       rd_ptr, wr_ptr;
      logic [PW:0]         count;
      logic [31:0]         mem_data  [DEPTH];
      logic [GC_WIDTH-1:0] mem_stamp [DEPTH];
      logic                sel, full, pop, byp, wr, rd;
      assign sel  = enq && enq_acc == AW'(i);
      assign full = count == (PW+1)'(DEPTH);
      assign drop[i] = sel && full;
      assign pop  = acc_req[i].valid && acc_req[i].ready;
`ifdef ACC_SENDER_BYPASS_EN
      assign byp  = sel && count == '0;
`else
      assign byp  = 1'b0;
`endif
      // a bypassed push that is accepted the same cycle never touches storage
      assign wr   = sel && !full && !(byp && acc_req[i].ready);
      assign rd   = pop && !byp;
      assign acc_req[i].valid = count != '0 || byp;
      assign acc_data[i] = byp ? enq_data : mem_data[rd_ptr];
      assign gc_stamp[i] = byp ? enq_stamp : mem_stamp[rd_ptr];
      assign acc_full[i] = full;
      assign busy[i] = count != '0;
      // FIFO pointers, occupancy and storage; storage cleared so outputs read zero after reset
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
               mem_data[k]  <= '0;
               mem_stamp[k] <= '0;
            end
         end else begin
            if (wr) begin
               mem_data[wr_ptr]  <= enq_data;
               mem_stamp[wr_ptr] <= enq_stamp;
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(wr) - (PW+1)'(rd);
         end
      end
   end
   assign idle = ~|busy;
   // sticky flag for any push that hit a full FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) overflow <= 1'b0;
      else if (|drop) overflow <= 1'b1;
   end
endmodule

// File: tb/tb_acc_sender.sv
// tb_acc_sender: queue-based reference model plus directed and random stimulus for acc_sender.
module tb_acc_sender;
   localparam int N = 3;
   localparam int D = 4;
   localparam int GW = 16;
`ifdef ACC_SENDER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b0, enq = 1'b0;
   logic [1:0] enq_acc = '0;
   logic [31:0] enq_data = '0;
   logic [GW-1:0] enq_stamp = '0;
   logic [N-1:0] acc_full, vld, rdy;
   logic [N-1:0][31:0] acc_data;
   logic [N-1:0][GW-1:0] gc_stamp;
   logic idle, overflow;
   int checks = 0, passes = 0;
   logic [47:0] q [N][$];
   logic m_ovf = 1'b0;
   logic [31:0] got [$];
   req_if acc_req [N] ();
   for (genvar g = 0; g < N; g++) begin : g_map
      assign vld[g] = acc_req[g].valid;
      assign acc_req[g].ready = rdy[g];
   end
   acc_sender #(.N_ACC(N), .DEPTH(D), .GC_WIDTH(GW)) dut (
      .clk(clk), .reset(reset), .enq(enq), .enq_acc(enq_acc), .enq_data(enq_data),
      .enq_stamp(enq_stamp), .acc_full(acc_full), .acc_req(acc_req), .acc_data(acc_data),
      .gc_stamp(gc_stamp), .idle(idle), .overflow(overflow));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic step();
      @(negedge clk);
      #1;
   endtask
   // reference model: one queue per accumulator, advanced on each accepted edge
   always @(posedge clk or posedge reset) begin : model
      int sz;
      if (reset) begin
         for (int i = 0; i < N; i++) q[i].delete();
         m_ovf <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            sz = q[i].size();
            if (enq && enq_acc == i && sz == D) m_ovf <= 1'b1;
            if (sz != 0 && rdy[i]) void'(q[i].pop_front());
            if (enq && enq_acc == i && sz < D && !(BYP && sz == 0 && rdy[i]))
               q[i].push_back({enq_stamp, enq_data});
         end
      end
   end
   // compare DUT against the model every cycle
   always @(negedge clk) begin : cmp
      logic ev;
      logic [47:0] ed;
      for (int i = 0; i < N; i++) begin
         ev = q[i].size() != 0 || (BYP && enq && enq_acc == i && !reset);
         ed = q[i].size() != 0 ? q[i][0] : {enq_stamp, enq_data};
         chk($sformatf("valid%0d", i), 64'(vld[i]), 64'(ev));
         if (ev) chk($sformatf("head%0d", i), {16'h0, gc_stamp[i], acc_data[i]}, {16'h0, ed});
         chk($sformatf("full%0d", i), 64'(acc_full[i]), 64'(q[i].size() == D));
      end
      chk("idle", 64'(idle), 64'(q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
   end
   initial begin
      int n;
      rdy = '0;
      #2 reset = 1'b1;
      step();
      chk("rst_valid", 64'(vld), 64'h0);
      chk("rst_data", 64'(acc_data), 64'h0);
      chk("rst_stamp", 64'(gc_stamp), 64'h0);
      chk("rst_idle", 64'(idle), 64'h1);
      chk("rst_full", 64'(acc_full), 64'h0);
      reset = 1'b0;
      step();
      // single request held off, then accepted
      enq = 1'b1; enq_acc = 2'd1; enq_data = 32'h3F800000; enq_stamp = 16'd5;
      step();
      enq = 1'b0;
      chk("t1_valid", 64'(vld[1]), 64'h1);
      chk("t1_idle", 64'(idle), 64'h0);
      for (int k = 0; k < 10; k++) begin
         chk("t1_data", 64'(acc_data[1]), 64'h3F800000);
         chk("t1_stamp", 64'(gc_stamp[1]), 64'h5);
         step();
      end
      rdy[1] = 1'b1;
      step();
      rdy[1] = 1'b0;
      chk("t1_popped", 64'(vld[1]), 64'h0);
      chk("t1_idle_back", 64'(idle), 64'h1);
      // fill acc 0, overflow, drain in order
      for (int k = 1; k <= 5; k++) begin
         enq = 1'b1; enq_acc = 2'd0; enq_data = 32'(k);
         step();
         if (k == 4) chk("fill_full", 64'(acc_full[0]), 64'h1);
      end
      enq = 1'b0;
      chk("fill_ovf", 64'(overflow), 64'h1);
      rdy[0] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("drain_data", 64'(acc_data[0]), 64'(k));
         step();
      end
      rdy[0] = 1'b0;
      chk("drain_empty", 64'(vld[0]), 64'h0);
      // async reset mid-cycle with two entries pending per FIFO
      for (int k = 0; k < 6; k++) begin
         enq = 1'b1; enq_acc = 2'(k % 3); enq_data = 32'(100 + k);
         step();
      end
      enq = 1'b0;
      chk("pre_rst_valid", 64'(vld), 64'h7);
      #1 reset = 1'b1;
      #1;
      chk("async_valid", 64'(vld), 64'h0);
      chk("async_idle", 64'(idle), 64'h1);
      chk("async_ovf", 64'(overflow), 64'h0);
      step();
      reset = 1'b0;
      step();
      // wrap-around on acc 2 with ready toggling
      n = 0;
      got.delete();
      for (int c = 0; c < 100 && got.size() < 10; c++) begin
         if (vld[2] && rdy[2]) got.push_back(acc_data[2]);
         rdy[2] = ~rdy[2];
         enq = n < 10 && q[2].size() < D - 1;
         enq_acc = 2'd2; enq_data = 32'(n);
         if (enq) n++;
         step();
      end
      enq = 1'b0; rdy[2] = 1'b0;
      chk("wrap_count", 64'(got.size()), 64'd10);
      for (int k = 0; k < got.size(); k++) chk("wrap_order", 64'(got[k]), 64'(k));
      // full FIFO with simultaneous push and pop
      for (int k = 10; k < 14; k++) begin
         enq = 1'b1; enq_acc = 2'd0; enq_data = 32'(k);
         step();
      end
      enq_data = 32'd99; rdy[0] = 1'b1;
      step();
      enq = 1'b0; rdy[0] = 1'b0;
      chk("pp_ovf", 64'(overflow), 64'h1);
      chk("pp_full", 64'(acc_full[0]), 64'h0);
      chk("pp_head", 64'(acc_data[0]), 64'd11);
      rdy[0] = 1'b1;
      n = 0;
      for (int c = 0; c < 10 && vld[0]; c++) begin
         n++;
         step();
      end
      rdy[0] = 1'b0;
      chk("pp_count", 64'(n), 64'd3);
`ifdef ACC_SENDER_BYPASS_EN
      enq = 1'b1; enq_acc = 2'd0; enq_data = 32'hABCD; rdy[0] = 1'b1;
      #1;
      chk("byp_valid", 64'(vld[0]), 64'h1);
      chk("byp_data", 64'(acc_data[0]), 64'hABCD);
      step();
      enq = 1'b0; rdy[0] = 1'b0;
      chk("byp_gone", 64'(vld[0]), 64'h0);
      chk("byp_idle", 64'(idle), 64'h1);
`endif
      // random traffic checked by the model
      for (int c = 0; c < 3000; c++) begin
         enq = 1'($urandom_range(0, 1));
         enq_acc = 2'($urandom_range(0, 2));
         enq_data = $urandom;
         enq_stamp = 16'($urandom);
         for (int i = 0; i < N; i++) rdy[i] = $urandom_range(0, 2) == 0;
         step();
      end
      enq = 1'b0;
      step();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/acc_sender.md
# acc_sender

Per-core initiator for the accumulator request channel. Buffers accumulate requests (accumulator index, 32-bit FP operand, global-commit stamp) produced by one core's commit stage in one FIFO per accumulator. Drives the `valid` side of the shared `req_if` handshake toward the parent FPR register file, which arbitrates across cores by stamp and feeds its fadd pipeline. Reports quiescence, so fork/join logic can wait until every request of this core has been accepted.

## Interface
- `N_ACC`, 3, number of accumulator registers; one FIFO and one `req_if` per accumulator.
- `DEPTH`, 4, entries per FIFO; must be a power of two, at least 2.
- `GC_WIDTH`, codebase `GC_WIDTH`, global-commit stamp width; stamps are signed.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enq`  in  1  push request from commit stage.
- `enq_acc`  in  $clog2(N_ACC)  target accumulator index; values at or above N_ACC are illegal.
- `enq_data`  in  32  FP operand.
- `enq_stamp`  in  GC_WIDTH  global-commit stamp of the instruction.
- `acc_full`  out  N_ACC  bit i is high when FIFO i holds DEPTH entries.
- `acc_req`  req_if[N_ACC]  initiator side; drives `valid`, samples `ready`.
- `acc_data`  out  32 × N_ACC  head operand of each FIFO.
- `gc_stamp`  out  GC_WIDTH × N_ACC  head stamp of each FIFO.
- `idle`  out  1  high when all FIFOs are empty.
- `overflow`  out  1  sticky; set by a push into a full FIFO.

## Operation
- FIFO i state: `rd_ptr` and `wr_ptr`, each log2(DEPTH) bits and wrapping modulo DEPTH; `count`, log2(DEPTH)+1 bits.
- Push into FIFO i: `enq && enq_acc==i && count<DEPTH`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- Push into a full FIFO:
  - the entry is dropped and no state in that FIFO changes;
  - `overflow` is set and stays set until reset.
- This holds even if the same FIFO pops in the same cycle. There is no pass-through when full.
- `acc_req[i].valid = (count_i != 0)`.
- `acc_data[i]` and `gc_stamp[i]` are the storage at `rd_ptr`.
- Pop FIFO i: `acc_req[i].valid && acc_req[i].ready`. `rd_ptr` then increments.
- Simultaneous push and pop on a FIFO that is not full: both take effect and `count` is unchanged.
- Once `valid` is high, `valid`, `acc_data` and `gc_stamp` stay stable until the pop cycle. The block never withdraws a request.
- `ready` may depend combinationally on `valid`, `acc_data` and `gc_stamp`. The block must not feed `ready` back combinationally into any of those outputs.
- FIFOs are independent; the block places no ordering constraint between accumulators.
- `idle = &(count_i==0)`. It is computed from registered counts, so a push in the current cycle does not yet clear it.

## Timing
- Reset state, applied asynchronously on assertion:
  - all pointers, counts and storage are 0;
  - `valid` = 0, `acc_data` = 0, `gc_stamp` = 0;
  - `acc_full` = 0, `idle` = 1, `overflow` = 0.
- Reset during a pending request drops `valid` immediately, without waiting for a clock edge. Buffered entries are lost.
- Latency without `ACC_SENDER_BYPASS_EN`: a push into an empty FIFO at edge N makes `valid` high after edge N, i.e. in cycle N+1.
- Throughput: one pop per accumulator per cycle while `ready` is held high.
- `acc_full[i]` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop.
- Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers return to 0 and entries remain in FIFO order.

## Configuration
- `ACC_SENDER_BYPASS_EN` defined:
  - a push into an empty FIFO presents `valid`, `acc_data = enq_data` and `gc_stamp = enq_stamp` combinationally in the same cycle;
  - if `ready` is high in that cycle, the request pops without ever being stored and `count` stays 0;
  - if `ready` is low, the entry is stored normally;
  - `idle` is unchanged by the bypass path; it stays registered.
- Not defined: no combinational path from `enq*` to `acc_req`, `acc_data` or `gc_stamp`. Latency is 1 cycle as specified under Timing.

## Test plan
- Reset, then push acc 1 with data 0x3F800000 and stamp 5, `ready` held 0:
  - from the next cycle, `acc_req[1].valid` = 1 with that data and stamp, stable for 10 cycles;
  - `idle` = 0;
  - raise `ready` for one cycle → `valid` = 0 and `idle` = 1 on the following cycle.
- Fill FIFO:
  - push 4 entries into acc 0 (data 1..4) with `ready` = 0 → `acc_full[0]` = 1;
  - a fifth push (data 5) → `overflow` = 1;
  - drain with `ready` = 1 → data 1, 2, 3, 4 in order, and 5 never appears.
- Wrap-around: 10 pushes into acc 2 (data 0..9) with `ready` toggling 1-0-1-0 → outputs 0..9 in order, none lost or duplicated.
- Full FIFO, simultaneous push and pop with `ready` = 1 → the pop is accepted, the push is dropped, `overflow` = 1 and `count` = 3.
- Assert `reset` asynchronously mid-cycle with 2 entries pending in each FIFO → all `valid` = 0, `idle` = 1, `overflow` = 0 before the next clock edge.
- With `ACC_SENDER_BYPASS_EN`: push into empty acc 0 with `ready` = 1 → `valid` and `enq_data` visible in the same cycle; after the edge, `valid` = 0 and `idle` stays 1.
